hs_rx_deserializer: RTL and testbench

//  D-PHY high-speed receive datapath; counterpart of the HS transmit path.

---
 rtl/hs_rx_pkg.sv | 24 ++
 rtl/hs_rx_deserializer_if.sv | 24 ++
 rtl/hs_rx_sync_det.sv | 36 +++
 rtl/hs_rx_deserializer.sv | 101 ++++++++++
 tb/tb_hs_rx_deserializer.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/hs_rx_pkg.sv
// Shared types and constants for the D-PHY HS receive deserializer.
// Also provides the Hamming-distance helper used by the sync detector.
package hs_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HUNT = 3'd1,
    ST_DATA = 3'd2,
    ST_FAIL = 3'd3
  } hs_rx_state_e;

  localparam logic [7:0]  HS_SYNC_WORD    = 8'hB8;
  localparam int unsigned HS_SYNC_TIMEOUT = 32;

  function automatic logic [3:0] hamming8(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] x;
    logic [3:0] n;
    x = a ^ b;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'd0, x[i]};
    return n;
  endfunction

endpackage

// File: rtl/hs_rx_deserializer_if.sv
// PPI-side bundle of the HS receive path: sampled bit pair in, bytes and status out.
// master = line sampler / protocol side, slave = the deserializer.
interface hs_rx_deserializer_if;
  logic       HSRX_EN;
  logic       HS_b1;
  logic       HS_b2;
  logic [7:0] RxDataHS;
  logic       RxValidHS;
  logic       RxActiveHS;
  logic       RxSyncHS;
  logic       ErrSotHS;
  logic       ErrSotSyncHS;
  logic [2:0] DphyRxState;

  modport master (
    output HSRX_EN, HS_b1, HS_b2,
    input  RxDataHS, RxValidHS, RxActiveHS, RxSyncHS, ErrSotHS, ErrSotSyncHS, DphyRxState
  );

  modport slave (
    input  HSRX_EN, HS_b1, HS_b2,
    output RxDataHS, RxValidHS, RxActiveHS, RxSyncHS, ErrSotHS, ErrSotSyncHS, DphyRxState
  );
endinterface

// File: rtl/hs_rx_sync_det.sv
// Combinational sync-word compare on the two candidate windows of the next history.
// HS_RX_SOT_TOLERANT_EN: also accept a window one bit away from the sync word.
module hs_rx_sync_det
  import hs_rx_pkg::*;
(
  input  logic [8:0] hist_i,
  input  logic [7:0] sync_word_i,
  output logic       match_a_o,
  output logic       match_b_o,
  output logic       err1_o
);

  logic [3:0] dist_a, dist_b;

  assign dist_a = hamming8(hist_i[8:1], sync_word_i);
  assign dist_b = hamming8(hist_i[7:0], sync_word_i);

`ifdef HS_RX_SOT_TOLERANT_EN
  logic exact_a, exact_b, near_a, near_b;

  assign exact_a = (dist_a == 4'd0);
  assign exact_b = (dist_b == 4'd0);
  assign near_a  = (dist_a == 4'd1);
  assign near_b  = (dist_b == 4'd1);

  // An exact hit on either window outranks a near hit on the other.
  assign match_b_o = exact_b | (~exact_a & near_b);
  assign match_a_o = exact_a | (~exact_b & ~near_b & near_a);
  assign err1_o    = ~exact_a & ~exact_b & (near_a | near_b);
`else
  assign match_a_o = (dist_a == 4'd0);
  assign match_b_o = (dist_b == 4'd0);
  assign err1_o    = 1'b0;
`endif

endmodule

// File: rtl/hs_rx_deserializer.sv
// D-PHY HS receive: sync hunt, byte alignment and 2b->8b deserialization.
// Optional SoT 1-bit error tolerance via HS_RX_SOT_TOLERANT_EN (see hs_rx_sync_det).
module hs_rx_deserializer
  import hs_rx_pkg::*;
#(
  parameter logic [7:0]  SYNC_WORD    = HS_SYNC_WORD,
  parameter int unsigned SYNC_TIMEOUT = HS_SYNC_TIMEOUT
) (
  input  logic                 RxDDRClk,
  input  logic                 RxRst,
  hs_rx_deserializer_if.slave  bus
);

  localparam int CW = $clog2(SYNC_TIMEOUT + 1);

  hs_rx_state_e  state_q;
  logic [6:0]    hist_q;
  logic [8:0]    hist_d;
  logic [CW-1:0] hunt_q;
  logic [2:0]    nbit_q;
  logic [7:0]    data_q;
  logic          valid_q, active_q, sync_q, errsot_q, tmo_q;
  logic          match_a, match_b, err1;

  // Newest bit at the MSB; history is dropped whenever the lane is disabled.
  assign hist_d = bus.HSRX_EN ? {bus.HS_b2, bus.HS_b1, hist_q} : 9'd0;

  hs_rx_sync_det u_sync_det (
    .hist_i      (hist_d),
    .sync_word_i (SYNC_WORD),
    .match_a_o   (match_a),
    .match_b_o   (match_b),
    .err1_o      (err1)
  );

  always_ff @(posedge RxDDRClk or negedge RxRst) begin
    if (!RxRst) begin
      state_q  <= ST_IDLE;
      hist_q   <= '0;
      hunt_q   <= '0;
      nbit_q   <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
      sync_q   <= 1'b0;
      errsot_q <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      hist_q   <= hist_d[8:2];
      valid_q  <= 1'b0;
      sync_q   <= 1'b0;
      errsot_q <= 1'b0;
      tmo_q    <= 1'b0;
      if (!bus.HSRX_EN) begin
        state_q  <= ST_IDLE;
        active_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q <= ST_HUNT;
            hunt_q  <= '0;
          end
          ST_HUNT: begin
            if (match_a | match_b) begin
              state_q  <= ST_DATA;
              active_q <= 1'b1;
              sync_q   <= 1'b1;
              errsot_q <= err1;
              // Window B leaves this cycle's b2 as data bit 0.
              nbit_q   <= match_b ? 3'd1 : 3'd0;
            end else if (hunt_q == CW'(SYNC_TIMEOUT - 1)) begin
              state_q <= ST_FAIL;
              tmo_q   <= 1'b1;
            end else begin
              hunt_q <= hunt_q + CW'(1);
            end
          end
          ST_DATA: begin
            // 3-bit count wraps mod 8, so the odd-phase remainder carries naturally.
            nbit_q <= nbit_q + 3'd2;
            if (nbit_q[2:1] == 2'b11) begin
              valid_q <= 1'b1;
              data_q  <= nbit_q[0] ? hist_d[7:0] : hist_d[8:1];
            end
          end
          ST_FAIL: ;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.RxDataHS     = data_q;
  assign bus.RxValidHS    = valid_q;
  assign bus.RxActiveHS   = active_q;
  assign bus.RxSyncHS     = sync_q;
  assign bus.ErrSotHS     = errsot_q;
  assign bus.ErrSotSyncHS = tmo_q;
  assign bus.DphyRxState  = state_q;

endmodule

// File: tb/tb_hs_rx_deserializer.sv
// Scoreboard bench: a bit-stream reference model queues expected events, a monitor checks them.
// Follows HS_RX_SOT_TOLERANT_EN in the same build.
module tb_hs_rx_deserializer;

  localparam logic [7:0] SYNC    = 8'hB8;
  localparam int         TIMEOUT = 32;

  typedef struct { int cyc; logic [7:0] data; } byte_ev_t;
  typedef struct { int cyc; logic err; } sync_ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  byte_ev_t   exp_bytes[$];
  sync_ev_t   exp_sync[$];
  int         exp_tmo[$];
  logic       stream[$];
  logic [7:0] pay[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  hs_rx_deserializer_if bus ();

  hs_rx_deserializer dut (
    .RxDDRClk (clk),
    .RxRst    (rst_n),
    .bus      (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_data"},   {24'd0, bus.RxDataHS},    32'd0);
    chk({tag, "_valid"},  {31'd0, bus.RxValidHS},   32'd0);
    chk({tag, "_active"}, {31'd0, bus.RxActiveHS},  32'd0);
    chk({tag, "_sync"},   {31'd0, bus.RxSyncHS},    32'd0);
    chk({tag, "_errsot"}, {31'd0, bus.ErrSotHS},    32'd0);
    chk({tag, "_errtmo"}, {31'd0, bus.ErrSotSyncHS}, 32'd0);
    chk({tag, "_state"},  {29'd0, bus.DphyRxState}, 32'd0);
  endtask

  // 8 consecutive wire bits ending at index e, first bit in the LSB; bits before the stream are 0.
  function automatic logic [7:0] win_at(input int e);
    logic [7:0] v;
    v = '0;
    for (int j = 0; j < 8; j++)
      if (e - 7 + j >= 0) v[j] = stream[e - 7 + j];
    return v;
  endfunction

  function automatic int dist_at(input int e);
    return $countones(win_at(e) ^ SYNC);
  endfunction

  // Stream = lead zeros, sync byte, payload (LSB first, truncated to nbits if >= 0), pad, trailer pairs.
  task automatic build(input int lead, input logic [7:0] sw, input int nbits, input int trail);
    logic [7:0] b;
    int n;
    stream.delete();
    for (int i = 0; i < lead; i++) stream.push_back(1'b0);
    for (int i = 0; i < 8; i++) stream.push_back(sw[i]);
    n = 0;
    foreach (pay[k]) begin
      b = pay[k];
      for (int i = 0; i < 8; i++)
        if (nbits < 0 || n < nbits) begin stream.push_back(b[i]); n++; end
    end
    if (stream.size() % 2 != 0) stream.push_back(1'b0);
    for (int i = 0; i < 2 * trail; i++) stream.push_back(1'b0);
  endtask

  // Pair c of the stream is driven at base+c; anything it causes is visible at base+c+1.
  task automatic run_packet(input int rst_pair);
    int p, e, base, cut;
    logic err;
    byte_ev_t be;
    sync_ev_t se;
    p = stream.size() / 2;
    e = -1;
    err = 1'b0;
    for (int c = 1; c <= TIMEOUT && c < p && e < 0; c++) begin
      if (dist_at(2 * c) == 0) e = 2 * c;
      else if (dist_at(2 * c + 1) == 0) e = 2 * c + 1;
`ifdef HS_RX_SOT_TOLERANT_EN
      else if (dist_at(2 * c) == 1) begin e = 2 * c; err = 1'b1; end
      else if (dist_at(2 * c + 1) == 1) begin e = 2 * c + 1; err = 1'b1; end
`endif
    end
    @(posedge clk); #1;
    base = cyc;
    cut = (rst_pair >= 0) ? base + rst_pair : 32'h7fffffff;
    if (e >= 0) begin
      se.cyc = base + e / 2 + 1;
      se.err = err;
      if (se.cyc < cut) exp_sync.push_back(se);
      for (int last = e + 8; last < 2 * p; last += 8) begin
        be.cyc  = base + last / 2 + 1;
        be.data = win_at(last);
        if (be.cyc < cut) exp_bytes.push_back(be);
      end
    end else if (p > TIMEOUT && base + TIMEOUT + 1 < cut) begin
      exp_tmo.push_back(base + TIMEOUT + 1);
    end
    for (int c = 0; c < p; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (c == rst_pair) begin
        rst_n = 1'b0;
        bus.HSRX_EN = 1'b0; bus.HS_b1 = 1'b0; bus.HS_b2 = 1'b0;
        #1 chk_idle("rst_mid");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        return;
      end
      bus.HSRX_EN = 1'b1;
      bus.HS_b1 = stream[2 * c];
      bus.HS_b2 = stream[2 * c + 1];
    end
    @(posedge clk); #1;
    bus.HSRX_EN = 1'b0; bus.HS_b1 = 1'b0; bus.HS_b2 = 1'b0;
    @(posedge clk); #1;
    chk("en_off_active", {31'd0, bus.RxActiveHS}, 32'd0);
    chk("en_off_state", {29'd0, bus.DphyRxState}, 32'd0);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin : monitor
    byte_ev_t be;
    sync_ev_t se;
    int te;
    if (rst_n) begin
      if (bus.RxValidHS) begin
        if (exp_bytes.size() == 0) chk("unexpected_valid", {31'd0, bus.RxValidHS}, 32'd0);
        else begin
          be = exp_bytes.pop_front();
          chk("byte_data", {24'd0, bus.RxDataHS}, {24'd0, be.data});
          chk("byte_cycle", cyc, be.cyc);
          chk("byte_active", {31'd0, bus.RxActiveHS}, 32'd1);
        end
      end
      if (bus.RxSyncHS) begin
        if (exp_sync.size() == 0) chk("unexpected_sync", {31'd0, bus.RxSyncHS}, 32'd0);
        else begin
          se = exp_sync.pop_front();
          chk("sync_cycle", cyc, se.cyc);
          chk("sync_errsot", {31'd0, bus.ErrSotHS}, {31'd0, se.err});
          chk("sync_active", {31'd0, bus.RxActiveHS}, 32'd1);
          chk("sync_state", {29'd0, bus.DphyRxState}, 32'd2);
        end
      end else if (bus.ErrSotHS) begin
        chk("errsot_alone", {31'd0, bus.ErrSotHS}, 32'd0);
      end
      if (bus.ErrSotSyncHS) begin
        if (exp_tmo.size() == 0) chk("unexpected_timeout", {31'd0, bus.ErrSotSyncHS}, 32'd0);
        else begin
          te = exp_tmo.pop_front();
          chk("timeout_cycle", cyc, te);
          chk("timeout_state", {29'd0, bus.DphyRxState}, 32'd3);
        end
      end
    end
  end

  initial begin
    int nb, lead, ab;
    logic [7:0] sw;
    bus.HSRX_EN = 1'b0; bus.HS_b1 = 1'b0; bus.HS_b2 = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_idle("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Phase 0 and phase 1 alignment of the same packet.
    pay = '{8'h5A, 8'hC3};
    build(12, SYNC, -1, 0); run_packet(-1);
    build(13, SYNC, -1, 0); run_packet(-1);

    // Zeros only: hunt timeout, then FAIL until disable.
    stream.delete();
    for (int i = 0; i < 80; i++) stream.push_back(1'b0);
    run_packet(-1);

    // Abort two bits into the third byte, then a clean resend.
    pay = '{8'h5A, 8'hC3, 8'h3C};
    build(12, SYNC, 18, 0); run_packet(-1);
    pay = '{8'h5A, 8'hC3};
    build(12, SYNC, -1, 0); run_packet(-1);

    // Sync with a single bit error; long trailer so the non-tolerant build can time out.
    pay = '{8'h5A};
    build(12, 8'hB9, -1, 30); run_packet(-1);

    // Async reset in the middle of the second byte.
    pay = '{8'h11, 8'h22, 8'h33};
    build(12, SYNC, -1, 0); run_packet(16);
    repeat (2) @(posedge clk);

    for (int t = 0; t < 30; t++) begin
      pay.delete();
      nb = $urandom_range(1, 4);
      for (int k = 0; k < nb; k++) pay.push_back(8'($urandom));
      lead = $urandom_range(2, 20);
      sw = ($urandom_range(0, 3) == 0) ? 8'hB9 : SYNC;
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 8 * nb - 1) : -1;
      build(lead, sw, ab, $urandom_range(0, 3));
      run_packet(-1);
    end

    repeat (4) @(posedge clk);
    chk("bytes_pending", exp_bytes.size(), 32'd0);
    chk("sync_pending", exp_sync.size(), 32'd0);
    chk("timeout_pending", exp_tmo.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
